// File: rtl/ofdm_cp_remover.sv
// OFDM receive front-end: strips the cyclic prefix from a non-throttleable sample stream,
// buffers whole symbols and hands them to the FFT as sop/eop-framed ready/valid packets.
module ofdm_cp_remover #(
    parameter int FFT_LEN    = 64,
    parameter int CP_LEN     = 16,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_sym_start,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic              overflow,
    output logic              sync_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CP_LEN > 1) ? $clog2(CP_LEN) : 1;
    localparam int SW = $clog2(FFT_LEN);
    localparam logic [CW-1:0] CP_LAST = CW'(CP_LEN - 1);
    localparam logic [SW-1:0] ST_LAST = SW'(FFT_LEN - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   LEN_C   = (AW + 1)'(FFT_LEN);

    typedef enum logic [1:0] {
        IDLE,
        SKIP_CP,
        STORE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cp_cnt;
    logic [SW-1:0]       st_cnt;
    logic [SW-1:0]       o_cnt;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         level;
    logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
    logic                s1_valid;
    logic [2*DATA_W-1:0] s1_data;

    logic        wr_en;
    logic        rd_en;
    logic        out_accept;
    logic        s1_accept;
    logic [AW:0] free_space;
    logic        admit_ok;

    // Two-stage read pipeline (memory read register, then output register); each stage
    // refills whenever the stage ahead of it is empty or being drained this cycle.
    assign out_accept = !out_valid || out_ready;
    assign s1_accept  = !s1_valid || out_accept;
    assign wr_en      = in_valid && (state == STORE);
    assign rd_en      = (level != '0) && s1_accept;
    assign free_space = DEPTH_C - level + {{AW{1'b0}}, rd_en};
    assign admit_ok   = free_space >= LEN_C;

    assign out_sop = out_valid && (o_cnt == '0);
    assign out_eop = out_valid && (o_cnt == ST_LAST);

    // Symbol admission FSM: the whole useful part is admitted only if it fits right now.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cp_cnt   <= '0;
            st_cnt   <= '0;
            overflow <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            overflow <= 1'b0;
            sync_err <= 1'b0;
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        if (in_sym_start) begin
                            if (CP_LEN == 1) begin
                                if (admit_ok) state <= STORE;
                                else          overflow <= 1'b1;
                            end else begin
                                cp_cnt <= CW'(1);
                                state  <= SKIP_CP;
                            end
                        end
                    end
                    SKIP_CP: begin
                        sync_err <= in_sym_start;
                        if (cp_cnt == CP_LAST) begin
                            cp_cnt <= '0;
                            if (admit_ok) begin
                                state <= STORE;
                            end else begin
                                overflow <= 1'b1;
                                state    <= IDLE;
                            end
                        end else begin
                            cp_cnt <= cp_cnt + 1'b1;
                        end
                    end
                    STORE: begin
                        sync_err <= in_sym_start;
                        if (st_cnt == ST_LAST) begin
                            st_cnt <= '0;
                            state  <= IDLE;
                        end else begin
                            st_cnt <= st_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {in_real, in_imag};
        if (rd_en) s1_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Output register holds while stalled, so data and framing stay stable under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            o_cnt     <= '0;
        end else begin
            if (s1_accept) s1_valid <= rd_en;
            if (out_accept) begin
                out_valid <= s1_valid;
                if (s1_valid) {out_real, out_imag} <= s1_data;
            end
            if (out_valid && out_ready) begin
                o_cnt <= (o_cnt == ST_LAST) ? '0 : o_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Directed bench for ofdm_cp_remover: each task drives one scenario and checks
// beats, framing, pulses and timing against hand-derived expectations.
module tb_ofdm_cp_remover;

    localparam int DATA_W = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_sym_start = 1'b0;
    logic [DATA_W-1:0] in_real = '0;
    logic [DATA_W-1:0] in_imag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_sop;
    logic              out_eop;
    logic [DATA_W-1:0] out_real;
    logic [DATA_W-1:0] out_imag;
    logic              overflow;
    logic              sync_err;

    int vectors = 0;
    int miscompares = 0;

    ofdm_cp_remover #(
        .FFT_LEN(64), .CP_LEN(16), .DATA_W(DATA_W), .FIFO_DEPTH(128)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sym_start(in_sym_start),
        .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_real(out_real), .out_imag(out_imag),
        .overflow(overflow), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Passive recorder sampled on the falling edge; tasks read it, never write it.
    logic [25:0] cur;
    logic [25:0] beats[$];
    int          beat_tick[$];
    int          tick = 0;
    int          ovf_cnt = 0;
    int          sync_cnt = 0;
    int          last_ovf_tick = -1;
    int          last_sync_tick = -1;
    int          stall_cnt = 0;
    int          stall_bad = 0;
    logic        prev_stall = 1'b0;
    logic [25:0] prev_word = '0;

    assign cur = {out_sop, out_eop, out_real, out_imag};

    always @(negedge clk) begin
        if (prev_stall) begin
            stall_cnt++;
            if (!out_valid || cur !== prev_word) stall_bad++;
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = cur;
        if (out_valid && out_ready) begin
            beats.push_back(cur);
            beat_tick.push_back(tick);
        end
        if (overflow) begin
            ovf_cnt++;
            last_ovf_tick = tick;
        end
        if (sync_err) begin
            sync_cnt++;
            last_sync_tick = tick;
        end
        tick++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [25:0] exp_beat(input int k);
        return {(k == 0), (k == 63), 12'(16 + k), 12'(-(16 + k))};
    endfunction

    function automatic logic [25:0] beat_at(input int idx);
        if (idx < beats.size()) return beats[idx];
        return 'x;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_beats(input int base, input int n, input int budget);
        for (int c = 0; c < budget && (beats.size() - base) < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 80-sample symbol (real=n, imag=-n); gap cycles between samples carry an
    // unqualified in_sym_start and junk data that the DUT must ignore.
    task automatic send_symbol(input int gap, input int extra_start,
                               output int store_tick, output int cp_tick, output int extra_tick);
        store_tick = -1;
        cp_tick    = -1;
        extra_tick = -1;
        for (int n = 0; n < 80; n++) begin
            in_valid     = 1'b1;
            in_sym_start = (n == 0) || (n == extra_start);
            in_real      = DATA_W'(n);
            in_imag      = DATA_W'(-n);
            @(posedge clk);
            #1;
            if (n == 15) cp_tick = tick;
            if (n == 16) store_tick = tick;
            if (n == extra_start) extra_tick = tick;
            in_valid     = 1'b0;
            in_sym_start = 1'b0;
            for (int g = 0; g < gap; g++) begin
                in_sym_start = 1'b1;
                in_real      = '1;
                @(posedge clk);
                #1;
                in_sym_start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic [28:0] obs;
        idle(2);
        obs = {out_valid, out_sop, out_eop, out_real, out_imag, overflow, sync_err};
        vectors++;
        if (obs !== 29'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got %h want 0", obs);
        end
        reset = 1'b0;
        out_ready = 1'b1;
        idle(3);
        obs = {out_valid, out_sop, out_eop, out_real, out_imag, overflow, sync_err};
        vectors++;
        if (obs !== 29'd0) begin
            miscompares++;
            $display("[TB] FAIL idle_outputs got %h want 0", obs);
        end
    endtask

    task automatic test_single_symbol();
        int base, ovf0, sync0, st, cp, ex;
        base = beats.size(); ovf0 = ovf_cnt; sync0 = sync_cnt;
        out_ready = 1'b1;
        send_symbol(0, -1, st, cp, ex);
        wait_beats(base, 64, 300);
        idle(20);
        vectors++;
        if (beats.size() - base !== 64) begin
            miscompares++;
            $display("[TB] FAIL single_count got %0d want 64", beats.size() - base);
        end
        for (int k = 0; k < 64; k++) begin
            vectors++;
            if (beat_at(base + k) !== exp_beat(k)) begin
                miscompares++;
                $display("[TB] FAIL single_beat%0d got %h want %h", k, beat_at(base + k), exp_beat(k));
            end
        end
        vectors++;
        if (beats.size() > base && beat_tick[base] !== st + 2) begin
            miscompares++;
            $display("[TB] FAIL single_latency got tick %0d want %0d", beat_tick[base], st + 2);
        end
        vectors++;
        if (beats.size() >= base + 64 && beat_tick[base + 63] - beat_tick[base] !== 63) begin
            miscompares++;
            $display("[TB] FAIL single_gapfree got span %0d want 63", beat_tick[base + 63] - beat_tick[base]);
        end
        vectors++;
        if ({ovf_cnt - ovf0, sync_cnt - sync0} !== {32'd0, 32'd0}) begin
            miscompares++;
            $display("[TB] FAIL single_pulses got ovf=%0d sync=%0d want 0 0", ovf_cnt - ovf0, sync_cnt - sync0);
        end
    endtask

    task automatic test_backpressure();
        int base, stall0, bad0, st, cp, ex;
        base = beats.size(); stall0 = stall_cnt; bad0 = stall_bad;
        fork
            send_symbol(0, -1, st, cp, ex);
            for (int c = 0; c < 600 && (beats.size() - base) < 64; c++) begin
                out_ready = (c % 2 == 0);
                @(posedge clk);
                #1;
            end
        join
        out_ready = 1'b1;
        wait_beats(base, 64, 300);
        idle(20);
        vectors++;
        if (beats.size() - base !== 64) begin
            miscompares++;
            $display("[TB] FAIL bp_count got %0d want 64", beats.size() - base);
        end
        for (int k = 0; k < 64; k++) begin
            vectors++;
            if (beat_at(base + k) !== exp_beat(k)) begin
                miscompares++;
                $display("[TB] FAIL bp_beat%0d got %h want %h", k, beat_at(base + k), exp_beat(k));
            end
        end
        vectors++;
        if (stall_bad - bad0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL bp_stable got %0d unstable stalls want 0", stall_bad - bad0);
        end
        vectors++;
        if (stall_cnt - stall0 < 20) begin
            miscompares++;
            $display("[TB] FAIL bp_stalls_seen got %0d want at least 20", stall_cnt - stall0);
        end
    endtask

    task automatic test_sparse();
        int base, sync0, st, cp, ex;
        base = beats.size(); sync0 = sync_cnt;
        out_ready = 1'b1;
        send_symbol(2, -1, st, cp, ex);
        wait_beats(base, 64, 300);
        idle(20);
        vectors++;
        if (beats.size() - base !== 64) begin
            miscompares++;
            $display("[TB] FAIL sparse_count got %0d want 64", beats.size() - base);
        end
        for (int k = 0; k < 64; k++) begin
            vectors++;
            if (beat_at(base + k) !== exp_beat(k)) begin
                miscompares++;
                $display("[TB] FAIL sparse_beat%0d got %h want %h", k, beat_at(base + k), exp_beat(k));
            end
        end
        vectors++;
        if (sync_cnt - sync0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL sparse_sync got %0d want 0", sync_cnt - sync0);
        end
    endtask

    task automatic test_overflow();
        int base, ovf0, sync0, st, cp, ex;
        base = beats.size(); ovf0 = ovf_cnt; sync0 = sync_cnt;
        out_ready = 1'b0;
        send_symbol(0, -1, st, cp, ex);
        send_symbol(0, -1, st, cp, ex);
        send_symbol(0, -1, st, cp, ex);
        idle(5);
        vectors++;
        if (ovf_cnt - ovf0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL ovf_count got %0d want 1", ovf_cnt - ovf0);
        end
        vectors++;
        if (last_ovf_tick !== cp) begin
            miscompares++;
            $display("[TB] FAIL ovf_timing got tick %0d want %0d", last_ovf_tick, cp);
        end
        vectors++;
        if ({out_valid, out_sop, out_real} !== {2'b11, 12'd16}) begin
            miscompares++;
            $display("[TB] FAIL ovf_head got v=%b sop=%b re=%0d want 1 1 16", out_valid, out_sop, out_real);
        end
        out_ready = 1'b1;
        wait_beats(base, 128, 400);
        idle(20);
        vectors++;
        if (beats.size() - base !== 128) begin
            miscompares++;
            $display("[TB] FAIL ovf_beats got %0d want 128", beats.size() - base);
        end
        for (int k = 0; k < 128; k++) begin
            vectors++;
            if (beat_at(base + k) !== exp_beat(k % 64)) begin
                miscompares++;
                $display("[TB] FAIL ovf_beat%0d got %h want %h", k, beat_at(base + k), exp_beat(k % 64));
            end
        end
        vectors++;
        if (sync_cnt - sync0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL ovf_sync got %0d want 0", sync_cnt - sync0);
        end
    endtask

    task automatic test_resync();
        int base, sync0, st, cp, ex;
        base = beats.size(); sync0 = sync_cnt;
        out_ready = 1'b1;
        send_symbol(0, 26, st, cp, ex);
        wait_beats(base, 64, 300);
        idle(20);
        vectors++;
        if (sync_cnt - sync0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL resync_count got %0d want 1", sync_cnt - sync0);
        end
        vectors++;
        if (last_sync_tick !== ex) begin
            miscompares++;
            $display("[TB] FAIL resync_timing got tick %0d want %0d", last_sync_tick, ex);
        end
        vectors++;
        if (beats.size() - base !== 64) begin
            miscompares++;
            $display("[TB] FAIL resync_beats got %0d want 64", beats.size() - base);
        end
        for (int k = 0; k < 64; k++) begin
            vectors++;
            if (beat_at(base + k) !== exp_beat(k)) begin
                miscompares++;
                $display("[TB] FAIL resync_beat%0d got %h want %h", k, beat_at(base + k), exp_beat(k));
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int base, base2, st, cp, ex;
        logic [28:0] obs;
        base = beats.size();
        out_ready = 1'b1;
        base2 = -1;
        for (int n = 0; n < 80; n++) begin
            in_valid     = 1'b1;
            in_sym_start = (n == 0);
            in_real      = DATA_W'(n);
            in_imag      = DATA_W'(-n);
            @(posedge clk);
            #1;
            in_valid     = 1'b0;
            in_sym_start = 1'b0;
            if (beats.size() - base >= 31) begin
                reset = 1'b1;
                #1;
                obs = {out_valid, out_sop, out_eop, out_real, out_imag, overflow, sync_err};
                vectors++;
                if (obs !== 29'd0) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_outputs got %h want 0", obs);
                end
                idle(2);
                obs = {out_valid, out_sop, out_eop, out_real, out_imag, overflow, sync_err};
                vectors++;
                if (obs !== 29'd0) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_held got %h want 0", obs);
                end
                reset = 1'b0;
                base2 = beats.size();
                break;
            end
        end
        vectors++;
        if (base2 < 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_trigger got no beat 30 want reset after beat 30");
            base2 = beats.size();
        end
        idle(30);
        vectors++;
        if (beats.size() - base2 !== 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_resume got %0d beats want 0", beats.size() - base2);
        end
        send_symbol(0, -1, st, cp, ex);
        wait_beats(base2, 64, 300);
        idle(20);
        vectors++;
        if (beats.size() - base2 !== 64) begin
            miscompares++;
            $display("[TB] FAIL midreset_count got %0d want 64", beats.size() - base2);
        end
        for (int k = 0; k < 64; k++) begin
            vectors++;
            if (beat_at(base2 + k) !== exp_beat(k)) begin
                miscompares++;
                $display("[TB] FAIL midreset_beat%0d got %h want %h", k, beat_at(base2 + k), exp_beat(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_symbol();
        test_backpressure();
        test_sparse();
        test_overflow();
        test_resync();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
